// File: rtl/muxn_rr_reg_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer family.
// Covers the arbitration mode encodings and the width helpers used by the parametrised blocks.
package muxn_rr_reg_pkg;

  localparam int MUX_MODE_RR    = 0;
  localparam int MUX_MODE_FIXED = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A channel index needs at least one bit, even when there is only one channel.
  function automatic int selWidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/muxn_rr_reg_rr_arbiter.sv
// Combinational arbiter that picks one requester, either round-robin from ptr or lowest index first.
// Produces a one-hot grant and the matching encoded index; the pointer register lives in the caller.
module rr_arbiter
  import muxn_rr_reg_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int MODE = MUX_MODE_RR,
  localparam int SELW = selWidth(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  // Scan N candidates; in round-robin the scan starts at ptr and wraps.
  always_comb begin
    int          w_idx;
    logic        w_found;
    logic [SELW-1:0] w_cand;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == MUX_MODE_FIXED) begin
        w_idx = k;
      end else begin
        w_idx = (int'(ptr) + k) % N;
      end
      w_cand = SELW'(w_idx);
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/muxn_rr_reg.sv
// N-channel arbitrating multiplexer with valid/ready handshakes and a single registered output beat.
// Accepts a new beat whenever the output register is empty or being drained in the same cycle.
module muxn_rr_reg
  import muxn_rr_reg_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int N    = 4,
  parameter  int MODE = MUX_MODE_RR,
  localparam int SELW = selWidth(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
);

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_sel;
  logic [SELW-1:0] r_ptr;

  logic            w_load_en;
  logic [N-1:0]    w_grant;
  logic [SELW-1:0] w_grant_idx;
  logic            w_xfer;
  logic [W-1:0]    w_sel_data;
  logic [SELW-1:0] w_ptr_next;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arbiter (
    .req       (in_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_load_en = !r_out_valid || out_ready;

  // Grants are suppressed while reset is asserted so no beat is offered during the reset cycle.
  assign in_ready = (rst_n && w_load_en) ? w_grant : '0;
  assign w_xfer   = |in_ready;

  assign w_ptr_next = (int'(w_grant_idx) == N - 1) ? '0 : w_grant_idx + SELW'(1);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SELW'(i)) begin
        w_sel_data = in_data[i*W +: W];
      end
    end
  end

  // Output stage: load on transfer, empty on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_grant_idx;
      if (MODE == MUX_MODE_RR) begin
        r_ptr <= w_ptr_next;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Bench for muxn_rr_reg: round-robin and fixed-priority instances share one stimulus stream
// and are checked every cycle against a transaction-level model, plus hand-computed checkpoints.
module tb_muxn_rr_reg;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstN;
  logic [N*W-1:0] inData;
  logic [N-1:0]   inValid;
  logic           outReady;

  logic [N-1:0]   rrReady, fpReady;
  logic [W-1:0]   rrData, fpData;
  logic           rrValid, fpValid;
  logic [1:0]     rrSel, fpSel;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  muxn_rr_reg #(.W(W), .N(N), .MODE(0)) dutRr (
    .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(rrReady),
    .out_data(rrData), .out_valid(rrValid), .out_ready(outReady), .out_sel(rrSel)
  );

  muxn_rr_reg #(.W(W), .N(N), .MODE(1)) dutFp (
    .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(fpReady),
    .out_data(fpData), .out_valid(fpValid), .out_ready(outReady), .out_sel(fpSel)
  );

  // Model state per arbitration mode: index 0 is round-robin, index 1 is fixed priority.
  logic       mValid [2];
  logic [7:0] mData  [2];
  int         mSel   [2];
  int         mPtr   [2];
  logic       modelLive = 1'b0;

  function automatic int pickChannel(input int mode, input int ptr, input logic [N-1:0] valid);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mode == 1) ? k : (ptr + k) % N;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] expReady(input int m);
    int g;
    if (!rstN) return '0;
    if (mValid[m] && !outReady) return '0;
    g = pickChannel(m, mPtr[m], inValid);
    if (g < 0) return '0;
    return 4'b0001 << g;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int g;
      if (!rstN) begin
        mValid[m] <= 1'b0;
        mData[m]  <= 8'h00;
        mSel[m]   <= 0;
        mPtr[m]   <= 0;
      end else begin
        g = (mValid[m] && !outReady) ? -1 : pickChannel(m, mPtr[m], inValid);
        if (g >= 0) begin
          mValid[m] <= 1'b1;
          mData[m]  <= inData[g*W +: W];
          mSel[m]   <= g;
          if (m == 0) mPtr[m] <= (g + 1) % N;
        end else if (outReady) begin
          mValid[m] <= 1'b0;
        end
      end
    end
    modelLive <= 1'b1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("rr out_valid", int'(rrValid), int'(mValid[0]));
      checkOutput("rr out_data",  int'(rrData),  int'(mData[0]));
      checkOutput("rr out_sel",   int'(rrSel),   mSel[0]);
      checkOutput("rr in_ready",  int'(rrReady), int'(expReady(0)));
      checkOutput("fp out_valid", int'(fpValid), int'(mValid[1]));
      checkOutput("fp out_data",  int'(fpData),  int'(mData[1]));
      checkOutput("fp out_sel",   int'(fpSel),   mSel[1]);
      checkOutput("fp in_ready",  int'(fpReady), int'(expReady(1)));
    end
  end

  task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic ordy);
    rstN     = rst;
    inValid  = valid;
    outReady = ordy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rstN     = 1'b0;
    inValid  = 4'hF;
    outReady = 1'b1;
    inData   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset held for two edges with every channel requesting.
    applyStimulus(1'b0, 4'hF, 1'b1);
    checkOutput("lit reset in_ready", int'(rrReady), 0);
    tick;
    tick;
    checkOutput("lit reset out_valid", int'(rrValid), 0);
    checkOutput("lit reset out_data",  int'(rrData), 0);
    checkOutput("lit reset out_sel",   int'(rrSel), 0);
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("lit release rr in_ready", int'(rrReady), 4'b0001);
    checkOutput("lit release fp in_ready", int'(fpReady), 4'b0001);

    // Round-robin with all channels busy: 0,1,2,3 repeating, no bubbles.
    for (int i = 0; i < 8; i++) begin
      tick;
      checkOutput("lit rr seq out_sel",   int'(rrSel), i % 4);
      checkOutput("lit rr seq out_data",  int'(rrData), 8'hA0 + (i % 4));
      checkOutput("lit rr seq out_valid", int'(rrValid), 1);
    end

    // Beat 0x5C from channel 2, then stall three cycles.
    inData[2*W +: W] = 8'h5C;
    applyStimulus(1'b1, 4'b0100, 1'b1);
    tick;
    checkOutput("lit stall load sel", int'(rrSel), 2);
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkOutput("lit stall in_ready", int'(rrReady), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("lit stall hold data",  int'(rrData), 8'h5C);
      checkOutput("lit stall hold sel",   int'(rrSel), 2);
      checkOutput("lit stall hold valid", int'(rrValid), 1);
      checkOutput("lit stall hold ready", int'(rrReady), 0);
    end
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("lit unstall rr in_ready", int'(rrReady), 4'b1000);
    tick;
    checkOutput("lit unstall out_sel", int'(rrSel), 3);
    checkOutput("lit unstall out_data", int'(rrData), 8'hA3);

    // Sparse requests: channel 1 alone, then channel 3 alone, then all.
    applyStimulus(1'b1, 4'b0010, 1'b1);
    tick;
    checkOutput("lit sparse sel1", int'(rrSel), 1);
    applyStimulus(1'b1, 4'b1000, 1'b1);
    tick;
    checkOutput("lit sparse sel3", int'(rrSel), 3);
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("lit sparse wrap in_ready", int'(rrReady), 4'b0001);
    tick;
    checkOutput("lit sparse wrap sel", int'(rrSel), 0);

    // Fixed priority: channels 0 and 2 requesting, then channel 2 alone.
    applyStimulus(1'b1, 4'b0101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("lit fp in_ready ch0", int'(fpReady), 4'b0001);
      tick;
      checkOutput("lit fp out_sel ch0", int'(fpSel), 0);
    end
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("lit fp in_ready ch2", int'(fpReady), 4'b0100);
    tick;
    checkOutput("lit fp out_sel ch2", int'(fpSel), 2);
    checkOutput("lit fp out_data ch2", int'(fpData), 8'h5C);

    // Reset while a beat is held under stall.
    applyStimulus(1'b1, 4'hF, 1'b0);
    tick;
    checkOutput("lit midstall valid", int'(rrValid), 1);
    applyStimulus(1'b0, 4'hF, 1'b0);
    checkOutput("lit midreset in_ready", int'(rrReady), 0);
    tick;
    checkOutput("lit midreset out_valid", int'(rrValid), 0);
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("lit restart rr in_ready", int'(rrReady), 4'b0001);
    tick;
    checkOutput("lit restart out_sel", int'(rrSel), 0);
    checkOutput("lit restart out_valid", int'(rrValid), 1);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      inData = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 19) != 0), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0));
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
